// File: rtl/pre_trace_streamer.sv
// Presynaptic trace store for the stdp stage: decays/increments every trace once per
// timestep, then replays spike and trace chunks row by row in stdp consumption order.
module pre_trace_streamer #(
    parameter int          LANES       = 24,
    parameter int          CHUNKS      = 24,
    parameter int          POSTS       = 18,
    parameter int          DW          = 16,
    parameter int          DECAY_SHIFT = 3,
    parameter int unsigned X_INC       = 4096
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_run,
    input  logic                      i_clear,
    input  logic [LANES*CHUNKS-1:0]   i_pre_spike_vec,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic [LANES-1:0]          o_pre_spike,
    output logic [LANES*DW-1:0]       o_x_trace,
    output logic                      o_done
);

    localparam int N  = LANES * CHUNKS;
    localparam int WW = LANES * DW;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int RW = (POSTS > 1) ? $clog2(POSTS) : 1;
    localparam logic [DW:0] INC_W = (DW + 1)'(X_INC);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        STREAM,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     chunk_q, chunk_d;
    logic [RW-1:0]     row_q, row_d;
    logic [N-1:0]      spike_q, spike_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [LANES-1:0]  pre_q, pre_d;
    logic [WW-1:0]     x_q, x_d;

    logic [WW-1:0]     trace_q [CHUNKS];
    logic [WW-1:0]     cur_word;
    logic [LANES-1:0]  cur_spk;
    logic [WW-1:0]     upd_word;
    logic [DW-1:0]     lane_x;
    logic [DW:0]       lane_sum;
    logic              clear_all;
    logic              wr_en;

    assign cur_word = trace_q[chunk_q];
    assign cur_spk  = spike_q[int'(chunk_q)*LANES +: LANES];

    // The extra top bit of lane_sum catches overflow; floor shift leaves small traces undecayed.
    always_comb begin
        upd_word = '0;
        lane_x   = '0;
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_x   = cur_word[DW*l +: DW];
            lane_sum = {1'b0, lane_x} - {1'b0, lane_x >> DECAY_SHIFT}
                       + (cur_spk[l] ? INC_W : '0);
            upd_word[DW*l +: DW] = lane_sum[DW] ? {DW{1'b1}} : lane_sum[DW-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        chunk_d   = chunk_q;
        row_d     = row_q;
        spike_d   = spike_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        pre_d     = '0;
        x_d       = '0;
        clear_all = 1'b0;
        wr_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                clear_all = i_clear;
                if (i_run) begin
                    spike_d = i_pre_spike_vec;
                    busy_d  = 1'b1;
                    chunk_d = '0;
                    row_d   = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                wr_en = 1'b1;
                if (chunk_q == CW'(CHUNKS - 1)) begin
                    chunk_d = '0;
                    state_d = STREAM;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            STREAM: begin
                valid_d = 1'b1;
                pre_d   = cur_spk;
                x_d     = cur_word;
                if (chunk_q == CW'(CHUNKS - 1)) begin
                    chunk_d = '0;
                    if (row_q == RW'(POSTS - 1)) begin
                        state_d = DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            chunk_q <= '0;
            row_q   <= '0;
            spike_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            pre_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            row_q   <= row_d;
            spike_q <= spike_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
            x_q     <= x_d;
        end
    end

    // Clear happens on the accepting edge, so a simultaneous run updates zeroed traces.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHUNKS; i++) begin
                trace_q[i] <= '0;
            end
        end else if (clear_all) begin
            for (int i = 0; i < CHUNKS; i++) begin
                trace_q[i] <= '0;
            end
        end else if (wr_en) begin
            trace_q[chunk_q] <= upd_word;
        end
    end

    assign o_busy      = busy_q;
    assign o_valid     = valid_q;
    assign o_done      = done_q;
    assign o_pre_spike = pre_q;
    assign o_x_trace   = x_q;

endmodule
